// File: rtl/sram_arbiter.sv
// Arbitrates one asynchronous 16-bit SRAM between a write requester and a read requester.
// Writes win ties unless a read has waited through WR_BURST_MAX consecutive write grants.
module sram_arbiter #(
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 16,
  parameter int ACC_CYC      = 2,
  parameter int WR_BURST_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_ack,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  output logic [DATA_W-1:0] o_SRAM_DQ,
  output logic              o_SRAM_DQ_OE,
  input  logic [DATA_W-1:0] i_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RECOVER} state_t;

  localparam logic [3:0] ACC_LAST  = 4'(ACC_CYC - 1);
  localparam logic [3:0] BURST_MAX = 4'(WR_BURST_MAX);

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [3:0]        streak_reg, streak_next;
  logic              is_wr_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] dq_reg;
  logic [DATA_W-1:0] rd_data_reg;
  logic              grant_wr, grant_rd;

  // A pending read only overrides a write once the write streak has saturated.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state_reg == IDLE) begin
      if (i_wr_req && !(i_rd_req && streak_reg == BURST_MAX)) grant_wr = 1'b1;
      else if (i_rd_req)                                        grant_rd = 1'b1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    streak_next = streak_reg;
    case (state_reg)
      IDLE: begin
        if (grant_wr) begin
          state_next = WRITE;
          cnt_next   = 4'd0;
          if (!i_rd_req)                    streak_next = 4'd0;
          else if (streak_reg != BURST_MAX) streak_next = streak_reg + 4'd1;
        end else if (grant_rd) begin
          state_next  = READ;
          cnt_next    = 4'd0;
          streak_next = 4'd0;
        end else if (!i_rd_req) begin
          streak_next = 4'd0;
        end
      end
      WRITE, READ: begin
        if (cnt_reg == ACC_LAST) state_next = RECOVER;
        else                     cnt_next   = cnt_reg + 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= 4'd0;
      streak_reg  <= 4'd0;
      is_wr_reg   <= 1'b0;
      addr_reg    <= '0;
      dq_reg      <= '0;
      rd_data_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      streak_reg <= streak_next;
      if (grant_wr) begin
        is_wr_reg <= 1'b1;
        addr_reg  <= i_wr_addr;
        dq_reg    <= i_wr_data;
      end else if (grant_rd) begin
        is_wr_reg <= 1'b0;
        addr_reg  <= i_rd_addr;
      end
      if (state_reg == READ && cnt_reg == ACC_LAST) rd_data_reg <= i_SRAM_DQ;
    end
  end

  // Strobes decode straight from state so an asynchronous reset releases the bus at once.
  always_comb begin
    o_busy       = (state_reg != IDLE);
    o_SRAM_CE_N  = !(state_reg == WRITE || state_reg == READ);
    o_SRAM_LB_N  = o_SRAM_CE_N;
    o_SRAM_UB_N  = o_SRAM_CE_N;
    o_SRAM_WE_N  = (state_reg != WRITE);
    o_SRAM_OE_N  = (state_reg != READ);
    o_SRAM_DQ_OE = (state_reg == WRITE);
    o_wr_ack     = (state_reg == RECOVER) && is_wr_reg;
    o_rd_ack     = (state_reg == RECOVER) && !is_wr_reg;
    o_SRAM_ADDR  = addr_reg;
    o_SRAM_DQ    = dq_reg;
    o_rd_data    = rd_data_reg;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small behavioural SRAM attached to the pins.
module tb_sram_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_req = 1'b0, rd_req = 1'b0;
  logic [19:0] wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ack, rd_ack, busy, dq_oe;
  logic [15:0] rd_data, dq_out, dq_in;
  logic [19:0] sram_addr;
  logic        we_n, ce_n, oe_n, lb_n, ub_n;

  int tests_run = 0;
  int tests_failed = 0;
  int conflicts = 0;

  logic [15:0] mem [0:255];

  always #5 clk = ~clk;

  sram_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_ack(rd_ack), .o_rd_data(rd_data),
    .o_busy(busy), .o_SRAM_ADDR(sram_addr), .o_SRAM_DQ(dq_out), .o_SRAM_DQ_OE(dq_oe),
    .i_SRAM_DQ(dq_in), .o_SRAM_WE_N(we_n), .o_SRAM_CE_N(ce_n), .o_SRAM_OE_N(oe_n),
    .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n)
  );

  // Behavioural SRAM: reads are combinational, writes land on the clock edge.
  assign dq_in = (!oe_n && !ce_n) ? mem[sram_addr[7:0]] : 16'hDEAD;
  always @(posedge clk) if (!we_n && !ce_n && dq_oe) mem[sram_addr[7:0]] <= dq_out;

  always @(negedge clk) if (dq_oe && !oe_n) conflicts++;

  function automatic logic [15:0] pattern(input int i);
    logic [3:0] a, b, c, d;
    a = 4'(i); b = 4'(i + 1); c = 4'(i + 2); d = 4'(i + 3);
    return {a, b, c, d};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({we_n, ce_n, oe_n, lb_n, ub_n, dq_oe, busy, wr_ack, rd_ack} !== 9'b111110000) begin
      tests_failed++;
      $display("FAIL reset_ctrl got %b want %b", {we_n, ce_n, oe_n, lb_n, ub_n, dq_oe, busy, wr_ack, rd_ack}, 9'b111110000);
    end
    tests_run++;
    if (sram_addr !== 20'h0 || dq_out !== 16'h0 || rd_data !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_data got addr=%h dq=%h rd=%h want 0", sram_addr, dq_out, rd_data);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset done");
  endtask

  task automatic test_single_write();
    logic [3:0] got, exp;
    wr_addr = 20'h00010; wr_data = 16'h1234; wr_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) wr_data = 16'hFFFF;
      exp = (k <= 2) ? 4'b0101 : (k == 3) ? 4'b1011 : 4'b1000;
      got = {we_n, dq_oe, wr_ack, busy};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL write_cyc%0d {we_n,oe,ack,busy} got %b want %b", k, got, exp);
      end
      if (k <= 2) begin
        tests_run++;
        if (dq_out !== 16'h1234 || sram_addr !== 20'h00010) begin
          tests_failed++;
          $display("FAIL write_bus%0d got dq=%h addr=%h want 1234/00010", k, dq_out, sram_addr);
        end
      end
      if (k == 3) wr_req = 1'b0;
    end
    $display("[TB] single write addr=00010 data=1234");
  endtask

  task automatic test_single_read();
    logic [3:0] got, exp;
    rd_addr = 20'h00010; rd_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      exp = (k <= 2) ? 4'b0001 : (k == 3) ? 4'b1011 : 4'b1000;
      got = {oe_n, dq_oe, rd_ack, busy};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL read_cyc%0d {oe_n,oe,ack,busy} got %b want %b", k, got, exp);
      end
      if (k >= 3) begin
        tests_run++;
        if (rd_data !== 16'h1234) begin
          tests_failed++;
          $display("FAIL read_data%0d got %h want 1234", k, rd_data);
        end
      end
      if (k == 3) rd_req = 1'b0;
    end
    $display("[TB] single read addr=00010 data=%h", rd_data);
  endtask

  task automatic test_both_held();
    int n_grants = 0, last_start = 0, cyc = 0;
    logic prev_w = 1'b0, prev_r = 1'b0;
    logic is_w;
    wr_addr = 20'h00020; wr_data = 16'hAAAA; rd_addr = 20'h00010;
    wr_req = 1'b1; rd_req = 1'b1;
    while (n_grants < 10 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if ((!we_n && !prev_w) || (!oe_n && !prev_r)) begin
        is_w = !we_n;
        tests_run++;
        if (is_w !== ((n_grants % 5) != 4)) begin
          tests_failed++;
          $display("FAIL both_order grant%0d got %s want %s", n_grants, is_w ? "W" : "R", ((n_grants % 5) != 4) ? "W" : "R");
        end
        if (n_grants > 0) begin
          tests_run++;
          if (cyc - last_start != 4) begin
            tests_failed++;
            $display("FAIL both_period grant%0d got %0d want 4", n_grants, cyc - last_start);
          end
        end
        $display("[TB] both held: grant %0d %s at cycle %0d", n_grants, is_w ? "W" : "R", cyc);
        last_start = cyc;
        n_grants++;
      end
      prev_w = !we_n;
      prev_r = !oe_n;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    tests_run++;
    if (n_grants != 10) begin
      tests_failed++;
      $display("FAIL both_count got %0d want 10", n_grants);
    end
    tests_run++;
    if (conflicts != 0) begin
      tests_failed++;
      $display("FAIL both_conflict got %0d want 0", conflicts);
    end
    for (int c = 0; c < 10 && busy; c++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_simul_after_reset();
    int lat = 0;
    rst = 1'b1;
    wr_addr = 20'h00040; wr_data = 16'h7777; rd_addr = 20'h00020;
    wr_req = 1'b1; rd_req = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({we_n, oe_n} !== 2'b01) begin
      tests_failed++;
      $display("FAIL simul_first {we_n,oe_n} got %b want 01", {we_n, oe_n});
    end
    for (int c = 2; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (wr_ack) lat = c;
    end
    wr_req = 1'b0;
    tests_run++;
    if (lat != 3) begin
      tests_failed++;
      $display("FAIL simul_wr_ack got cycle %0d want 3", lat);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if ({we_n, oe_n} !== 2'b10) begin
      tests_failed++;
      $display("FAIL simul_second {we_n,oe_n} got %b want 10", {we_n, oe_n});
    end
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (rd_ack) lat = c;
    end
    rd_req = 1'b0;
    tests_run++;
    if (lat == 0 || rd_data !== 16'hAAAA) begin
      tests_failed++;
      $display("FAIL simul_rd got ack_cycle=%0d data=%h want data AAAA", lat, rd_data);
    end
    $display("[TB] simultaneous after reset: W then R data=%h", rd_data);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    int acks = 0, lat = 0;
    wr_addr = 20'h00050; wr_data = 16'h9999; wr_req = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if ({we_n, ce_n, dq_oe} !== 3'b110) begin
      tests_failed++;
      $display("FAIL rstmid_strobes {we_n,ce_n,oe} got %b want 110", {we_n, ce_n, dq_oe});
    end
    wr_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (wr_ack) acks++;
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (wr_ack) acks++;
    end
    tests_run++;
    if (acks != 0 || rd_data !== 16'h0) begin
      tests_failed++;
      $display("FAIL rstmid_abort got acks=%0d rd_data=%h want 0/0000", acks, rd_data);
    end
    wr_addr = 20'h00030; wr_data = 16'h5A5A; wr_req = 1'b1;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1 && (we_n !== 1'b0 || dq_out !== 16'h5A5A)) begin
        tests_run++;
        tests_failed++;
        $display("FAIL rstmid_fresh_bus got we_n=%b dq=%h want 0/5a5a", we_n, dq_out);
      end
      if (wr_ack) lat = c;
    end
    wr_req = 1'b0;
    tests_run++;
    if (lat != 3) begin
      tests_failed++;
      $display("FAIL rstmid_fresh_ack got cycle %0d want 3", lat);
    end
    $display("[TB] reset mid-write: acks=%0d fresh write ack cycle %0d", acks, lat);
    @(negedge clk);
  endtask

  task automatic test_streaming();
    int wr_lat, rd_lat;
    logic [15:0] got;
    for (int i = 0; i <= 16; i++) begin
      wr_lat = 0; rd_lat = 0; got = 16'h0;
      if (i < 16) begin
        wr_addr = 20'h00100 + 20'(i); wr_data = pattern(i); wr_req = 1'b1;
      end
      if (i > 0) begin
        rd_addr = 20'h00100 + 20'(i - 1); rd_req = 1'b1;
      end
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (wr_ack && wr_req) begin wr_lat = c; wr_req = 1'b0; end
        if (rd_ack && rd_req) begin rd_lat = c; got = rd_data; rd_req = 1'b0; end
      end
      wr_req = 1'b0; rd_req = 1'b0;
      if (i < 16) begin
        tests_run++;
        if (wr_lat == 0) begin
          tests_failed++;
          $display("FAIL stream_wr%0d got no ack within 8 want ack", i);
        end
      end
      if (i > 0) begin
        tests_run++;
        if (rd_lat == 0 || got !== pattern(i - 1)) begin
          tests_failed++;
          $display("FAIL stream_rd%0d got lat=%0d data=%h want data %h", i - 1, rd_lat, got, pattern(i - 1));
        end
      end
      $display("[TB] stream period %0d wr_lat=%0d rd_lat=%0d rd_data=%h", i, wr_lat, rd_lat, got);
      repeat (367) @(negedge clk);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'h0;
    test_reset();
    test_single_write();
    test_single_read();
    test_both_held();
    test_simul_after_reset();
    test_reset_mid_write();
    test_streaming();
    tests_run++;
    if (conflicts != 0) begin
      tests_failed++;
      $display("FAIL final_conflict got %0d want 0", conflicts);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external 16-bit SRAM between the recorder (write port) and the player (read port).
- Sequences the SRAM control strobes and the DQ tri-state enable.
- Sits between the recorder/player FSMs and the SRAM pins in Top. The top-level inout io_SRAM_DQ is built from o_SRAM_DQ, o_SRAM_DQ_OE and i_SRAM_DQ.
- Uses fixed write priority with a starvation guard for reads.

Parameters:
ADDR_W, 20, SRAM address width
DATA_W, 16, SRAM data width
ACC_CYC, 2, cycles the strobes (WE_N or OE_N) stay asserted per access; legal range 1..15
WR_BURST_MAX, 4, max consecutive write grants while a read is pending; legal range 1..15

Ports:
i_clk  in  1  system clock (12 MHz audio clock domain)
i_rst  in  1  asynchronous active-high reset
i_wr_req  in  1  recorder write request, level, held until ack
i_wr_addr  in  ADDR_W  write address
i_wr_data  in  DATA_W  write data
o_wr_ack  out  1  one-cycle pulse: write done
i_rd_req  in  1  player read request, level, held until ack
i_rd_addr  in  ADDR_W  read address
o_rd_ack  out  1  one-cycle pulse: o_rd_data valid
o_rd_data  out  DATA_W  read data, held until next read completes
o_busy  out  1  high whenever state is not IDLE
o_SRAM_ADDR  out  ADDR_W  SRAM address
o_SRAM_DQ  out  DATA_W  data driven to SRAM
o_SRAM_DQ_OE  out  1  1 = drive DQ pins
i_SRAM_DQ  in  DATA_W  data sampled from SRAM
o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N  out  1 each  SRAM strobes, active-low

Behaviour:
- Clocking: single clock and single edge (posedge i_clk). i_rst is asynchronous and active-high.
- Reset values:
  - All _N strobes = 1.
  - o_SRAM_ADDR = 0, o_SRAM_DQ = 0, o_SRAM_DQ_OE = 0.
  - o_wr_ack = 0, o_rd_ack = 0, o_rd_data = 0, o_busy = 0.
  - Streak counter = 0, state = IDLE.
- States: IDLE -> WRITE or READ -> RECOVER -> IDLE.
- IDLE arbitration (evaluated every cycle):
  - Only wr_req: grant write.
  - Only rd_req: grant read.
  - Both: grant write unless streak == WR_BURST_MAX, in which case grant read.
  - Neither: stay in IDLE with strobes deasserted.
  - On grant, latch the address (and data for writes) into internal registers. Later changes on the i_* buses are ignored.
- WRITE (ACC_CYC cycles):
  - ADDR = latched address, DQ = latched data, DQ_OE = 1.
  - CE_N = 0, LB_N = UB_N = 0, WE_N = 0, OE_N = 1.
- READ (ACC_CYC cycles):
  - DQ_OE = 0, CE_N = 0, LB_N = UB_N = 0, OE_N = 0, WE_N = 1.
  - i_SRAM_DQ is registered into o_rd_data on the last READ cycle.
- RECOVER (1 cycle):
  - All strobes = 1, DQ_OE = 0; ADDR and DQ hold their values.
  - Pulse o_wr_ack or o_rd_ack for this cycle only.
  - This cycle guarantees the bus turnaround and the WE_N high time.
- Latency: grant in IDLE at cycle 0, ack at cycle ACC_CYC+1. Back-to-back period is ACC_CYC+2 cycles (4 cycles with the default).
- Requester rule: a requester may keep req high after its ack to chain the next access. The arbiter re-samples in IDLE on the cycle after RECOVER, so there is no double grant for a single request.
- Streak counter:
  - Increments on each write grant while rd_req = 1.
  - Clears on a read grant, or in any IDLE cycle where rd_req = 0.
  - Saturates at WR_BURST_MAX.
- Width rules: no address arithmetic; addresses pass through unmodified, so wrap-around is the requester's responsibility. ACC_CYC counter width is 4 bits.
- Requests dropped early: a req deasserted before ack does not cancel an access already granted; the ack still pulses. Requests absent in IDLE are not remembered.
- Reset mid-access: strobes go high and DQ_OE goes low immediately (asynchronously). The access is aborted, no ack is issued, and o_rd_data is cleared.
- Conflict guarantee: DQ_OE = 1 and OE_N = 0 are never true in the same cycle.

Test Plan:
1. Single write (wr_addr = 20'h00010, wr_data = 16'h1234, ACC_CYC = 2) -> WE_N low for exactly 2 cycles with DQ = 16'h1234 and DQ_OE = 1; wr_ack pulses at cycle 3 after grant; o_busy low at cycle 4.
2. Single read (rd_addr = 20'h00010; SRAM model returns 16'h1234) -> OE_N low for 2 cycles with DQ_OE = 0; rd_ack pulses with o_rd_data = 16'h1234, which holds afterwards.
3. Both req held continuously (WR_BURST_MAX = 4) -> grant order W, W, W, W, R, W, W, W, W, R...; each grant is 4 cycles apart; no cycle has DQ_OE = 1 while OE_N = 0.
4. Simultaneous req in the first IDLE cycle after reset -> write granted first; read granted next (streak = 1 < 4) only after wr_req drops.
5. i_rst asserted in the second WRITE cycle -> WE_N = 1 and DQ_OE = 0 within the same timestep; no wr_ack; after release, a fresh wr_req is granted normally.
6. Recorder streams 16 writes at 32 kHz while the player streams reads -> every request acked within 2×(ACC_CYC+2) cycles; read data matches the written pattern 16'h0123..16'hF012.
